collision_probe: RTL and testbench
==================================

# collision_probe

Upstream neighbour of the player state-update stage: produces the `is_collide` vector (up, down, left, right) and a hazard flag from the player's current `pos_x`/`pos_y` by probing a tile-map ROM. It runs a fixed 10-cycle scan loop. Each scan snapshots the position, issues eight tile lookups through a 1-cycle-latency ROM port, and commits all results atomically.

## Interface
- `TILE_SHIFT`, 5: tile size is 2^TILE_SHIFT = 32 px.
- `MAP_COLS`, 25: tiles per map row.
- `MAP_ROWS`, 19: tile rows.
- `SCREEN_W`, 800: playfield width in px.
- `SCREEN_H`, 608: playfield height in px.
- `HIT_W`, 24: hitbox width; legal range 1..32.
- `HIT_H`, 32: hitbox height; legal range 1..32.
- `ADDR_W`, 9: map address width; must satisfy 2^ADDR_W ≥ MAP_COLS*MAP_ROWS.
- `clk`  in  1: system clock, rising-edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `pos_x`  in  10: hitbox left edge in px.
- `pos_y`  in  10: hitbox top edge in px.
- `map_rd`  out  1: ROM read strobe.
- `map_addr`  out  ADDR_W: tile index, computed as row*MAP_COLS + col.
- `map_data`  in  2: tile code, valid on the cycle after `map_rd`. Codes: 00 empty, 01 solid, 10 spike, 11 solid.
- `is_collide`  out  4: {up, down, left, right}; 1 = blocked.
- `hazard`  out  1: a spike tile touches the hitbox border.
- `scan_done`  out  1: one-cycle pulse when new results are committed.

## Operation
- Edges: x0=pos_x, x1=pos_x+HIT_W-1, y0=pos_y, y1=pos_y+HIT_H-1. All edge arithmetic is 11-bit with no wrap.
- Probes, in fixed order:
  - 0: (x0, y0-1). 1: (x1, y0-1).
  - 2: (x0, y1+1). 3: (x1, y1+1).
  - 4: (x0-1, y0). 5: (x0-1, y1).
  - 6: (x1+1, y0). 7: (x1+1, y1).
- Each probe's tile is col = px>>TILE_SHIFT, row = py>>TILE_SHIFT. Compute row*MAP_COLS with shifts and adds; no multiplier.
- Out-of-bounds probes: px<0, py<0, px≥SCREEN_W or py≥SCREEN_H.
  - The probe slot still occupies its cycle, but `map_rd` is 0 and `map_addr` holds its previous value.
  - The result is forced to solid and non-hazard.
- Side result: a side bit is 1 if either of its two probes reads 01 or 11, or is out of bounds.
- `hazard` is 1 if any in-bounds probe reads 10. A spike is never solid.
- State machine: SNAP → ISSUE (8 cycles, counter k=0..7) → DRAIN → SNAP. It loops forever; there is no idle state.
  - SNAP: latch pos_x/pos_y into internal registers and clear the accumulators.
  - ISSUE k: drive probe k.
  - DRAIN: sample the last probe's data, then commit accumulators to `is_collide`/`hazard` at the end of the cycle.
- Position changes during a scan do not affect that scan; only the SNAP-cycle value is used.
- Reset values: `is_collide`=0000, `hazard`=0, `scan_done`=0, `map_rd`=0, `map_addr`=0, state=SNAP, k=0.
- Reset asserted mid-scan aborts the scan immediately; partial results are never committed.

## Timing
- Scan period is exactly 10 cycles. Cycle 0 is SNAP, cycles 1–8 are ISSUE probes 0–7, cycle 9 is DRAIN.
- `map_rd`/`map_addr` for probe k are registered outputs and are valid during cycle k+1.
- `map_data` for probe k is sampled at the end of cycle k+2; probe 7 is therefore sampled in DRAIN.
- `is_collide`/`hazard` update at the clock edge ending DRAIN. `scan_done` is high for the following cycle, which is the next SNAP.
- Outputs hold stable for the 10 cycles between commits.
- Latency from the `pos_*` sample to the result: 10 cycles.
- First `scan_done` after `rst_n` rises: the 10th rising edge after release.

## Test plan
- Reset:
  - Pulse `rst_n` low during ISSUE k=4 → all outputs 0 asynchronously, with no commit of partial data.
  - After release → `map_rd` high on cycles 1–8 and `scan_done` on the 10th edge.
- Floor: row 18 solid, pos=(200,544) → probes 2 and 3 address 18*25+6=456 → `is_collide`=0100, `hazard`=0.
- Left border: pos=(0,300), open map → `map_rd`=0 during cycles 5 and 6 → `is_collide`=0010.
- Spike: tile 456 = 10, pos=(200,544) → `is_collide`=0000, `hazard`=1.
- Straddle: only tile 457 (col 7, row 18) solid, pos=(210,544) → probe 2 addr 456 reads empty, probe 3 addr 457 reads solid → `is_collide`=0100.
- Snapshot: change pos_y from 544 to 300 during cycle 3 → the current commit still reports 0100 and the next scan reports 0000.

Source files
------------

// File: rtl/collision_probe.sv
// Scans the tile map around the player hitbox in a fixed 10-cycle loop and
// atomically commits the four blocked-side bits plus a spike-hazard flag.
module collision_probe #(
   parameter int TILE_SHIFT = 5,
   parameter int MAP_COLS   = 25,
   parameter int MAP_ROWS   = 19,
   parameter int SCREEN_W   = 800,
   parameter int SCREEN_H   = 608,
   parameter int HIT_W      = 24,
   parameter int HIT_H      = 32,
   parameter int ADDR_W     = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   output logic              map_rd,
   output logic [ADDR_W-1:0] map_addr,
   input  logic [1:0]        map_data,
   output logic [3:0]        is_collide,
   output logic              hazard,
   output logic              scan_done
);

   localparam int CW      = 11;
   localparam int RW      = CW - TILE_SHIFT;
   localparam int MC_BITS = $clog2(MAP_COLS + 1);
   localparam logic [31:0]   MC     = MAP_COLS;
   localparam logic [CW-1:0] HW_M1  = CW'(HIT_W - 1);
   localparam logic [CW-1:0] HH_M1  = CW'(HIT_H - 1);
   localparam logic [CW-1:0] SW     = CW'(SCREEN_W);
   localparam logic [CW-1:0] SH     = CW'(SCREEN_H);
   localparam logic [RW-1:0] COLS_L = RW'(MAP_COLS);
   localparam logic [RW-1:0] ROWS_L = RW'(MAP_ROWS);

   typedef enum logic [1:0] {ST_SNAP, ST_ISSUE, ST_DRAIN} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        k_reg, k_next;
   logic [9:0]        snap_x_reg, snap_y_reg;
   logic [3:0]        acc_col_reg, acc_col_next;
   logic              acc_haz_reg, acc_haz_next;
   logic              rd_oob_reg, samp_oob_reg;

   logic              issue_en, probe_oob, samp_en;
   logic [2:0]        probe_idx, samp_idx;
   logic [CW-1:0]     src_x, src_y, x0, x1, y0, y1, px, py;
   logic [RW-1:0]     probe_col, probe_row;
   logic [ADDR_W-1:0] probe_addr;
   logic [ADDR_W-1:0] row_term [MC_BITS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_SNAP;
         k_reg     <= 3'd0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      case (state_reg)
         ST_SNAP: begin
            state_next = ST_ISSUE;
            k_next     = 3'd0;
         end
         ST_ISSUE: begin
            if (k_reg == 3'd7) begin
               state_next = ST_DRAIN;
               k_next     = 3'd0;
            end else begin
               k_next = k_reg + 3'd1;
            end
         end
         ST_DRAIN: state_next = ST_SNAP;
         default:  state_next = ST_SNAP;
      endcase
   end

   // Outputs are registered, so each cycle prepares the probe shown next cycle;
   // probe 0 is built during SNAP from the live position being snapshotted.
   always_comb begin
      issue_en  = (state_reg == ST_SNAP) || ((state_reg == ST_ISSUE) && (k_reg != 3'd7));
      probe_idx = (state_reg == ST_SNAP) ? 3'd0 : k_reg + 3'd1;
      src_x     = (state_reg == ST_SNAP) ? {1'b0, pos_x} : {1'b0, snap_x_reg};
      src_y     = (state_reg == ST_SNAP) ? {1'b0, pos_y} : {1'b0, snap_y_reg};
      x0 = src_x;
      x1 = src_x + HW_M1;
      y0 = src_y;
      y1 = src_y + HH_M1;
      case (probe_idx)
         3'd0:    begin px = x0;         py = y0 - 11'd1; end
         3'd1:    begin px = x1;         py = y0 - 11'd1; end
         3'd2:    begin px = x0;         py = y1 + 11'd1; end
         3'd3:    begin px = x1;         py = y1 + 11'd1; end
         3'd4:    begin px = x0 - 11'd1; py = y0;         end
         3'd5:    begin px = x0 - 11'd1; py = y1;         end
         3'd6:    begin px = x1 + 11'd1; py = y0;         end
         default: begin px = x1 + 11'd1; py = y1;         end
      endcase
      probe_col = px[CW-1:TILE_SHIFT];
      probe_row = py[CW-1:TILE_SHIFT];
      // A coordinate of -1 wraps to 2047 and so fails the screen bound too.
      probe_oob = (px >= SW) || (py >= SH) || (probe_col >= COLS_L) || (probe_row >= ROWS_L);
   end

   // row*MAP_COLS as a sum of shifted copies, one per set bit of MAP_COLS.
   genvar gi;
   generate
      for (gi = 0; gi < MC_BITS; gi++) begin : g_row_mul
         assign row_term[gi] = MC[gi] ? (ADDR_W'(probe_row) << gi) : '0;
      end
   endgenerate

   always_comb begin
      probe_addr = ADDR_W'(probe_col);
      for (int i = 0; i < MC_BITS; i++) begin
         probe_addr = probe_addr + row_term[i];
      end
   end

   // Data for probe k arrives in cycle k+2: ISSUE k+1, or DRAIN for probe 7.
   always_comb begin
      samp_en      = ((state_reg == ST_ISSUE) && (k_reg != 3'd0)) || (state_reg == ST_DRAIN);
      samp_idx     = (state_reg == ST_DRAIN) ? 3'd7 : k_reg - 3'd1;
      acc_col_next = acc_col_reg;
      acc_haz_next = acc_haz_reg;
      if (samp_en) begin
         case (samp_idx[2:1])
            2'd0:    acc_col_next[3] = acc_col_reg[3] | samp_oob_reg | map_data[0];
            2'd1:    acc_col_next[2] = acc_col_reg[2] | samp_oob_reg | map_data[0];
            2'd2:    acc_col_next[1] = acc_col_reg[1] | samp_oob_reg | map_data[0];
            default: acc_col_next[0] = acc_col_reg[0] | samp_oob_reg | map_data[0];
         endcase
         acc_haz_next = acc_haz_reg | (!samp_oob_reg && (map_data == 2'b10));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_x_reg   <= '0;
         snap_y_reg   <= '0;
         acc_col_reg  <= '0;
         acc_haz_reg  <= 1'b0;
         rd_oob_reg   <= 1'b0;
         samp_oob_reg <= 1'b0;
         map_rd       <= 1'b0;
         map_addr     <= '0;
         is_collide   <= '0;
         hazard       <= 1'b0;
         scan_done    <= 1'b0;
      end else begin
         if (state_reg == ST_SNAP) begin
            snap_x_reg  <= pos_x;
            snap_y_reg  <= pos_y;
            acc_col_reg <= '0;
            acc_haz_reg <= 1'b0;
         end else begin
            acc_col_reg <= acc_col_next;
            acc_haz_reg <= acc_haz_next;
         end
         if (issue_en && !probe_oob) begin
            map_rd   <= 1'b1;
            map_addr <= probe_addr;
         end else begin
            map_rd <= 1'b0;
         end
         rd_oob_reg   <= probe_oob;
         samp_oob_reg <= rd_oob_reg;
         scan_done    <= (state_reg == ST_DRAIN);
         if (state_reg == ST_DRAIN) begin
            is_collide <= acc_col_next;
            hazard     <= acc_haz_next;
         end
      end
   end

endmodule

// File: tb/tb_collision_probe.sv
// Bench for collision_probe: behavioural tile ROM, table of position/map
// vectors with a result scoreboard, plus timing and reset corner sequences.
module tb_collision_probe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] pos_x, pos_y;
   logic       map_rd;
   logic [8:0] map_addr;
   logic [1:0] map_data;
   logic [3:0] is_collide;
   logic       hazard;
   logic       scan_done;

   int compared   = 0;
   int mismatched = 0;

   logic [1:0] map_mem [0:511];

   typedef struct {
      int         kind;
      logic [9:0] x;
      logic [9:0] y;
      logic [3:0] col;
      logic       haz;
   } vec_t;

   typedef struct {
      logic [3:0] col;
      logic       haz;
   } exp_t;

   vec_t vecs [13];
   exp_t sb_q [$];

   collision_probe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .map_rd     (map_rd),
      .map_addr   (map_addr),
      .map_data   (map_data),
      .is_collide (is_collide),
      .hazard     (hazard),
      .scan_done  (scan_done)
   );

   always #5 clk = ~clk;

   // 1-cycle ROM; returns a spike code when not strobed so unmasked OOB slots show up.
   always @(posedge clk) begin
      if (map_rd) map_data <= map_mem[map_addr];
      else        map_data <= 2'b10;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_map(input int kind);
      for (int i = 0; i < 512; i++) map_mem[i] = 2'b00;
      case (kind)
         1: for (int c = 0; c < 25; c++) map_mem[450 + c] = 2'b01;
         2: map_mem[456] = 2'b10;
         3: map_mem[457] = 2'b01;
         4: map_mem[406] = 2'b11;
         5: map_mem[450] = 2'b10;
         6: map_mem[432] = 2'b01;
         default: ;
      endcase
   endtask

   task automatic push_exp(input logic [3:0] col, input logic haz);
      exp_t e;
      e.col = col;
      e.haz = haz;
      sb_q.push_back(e);
   endtask

   task automatic compare_head(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL %s: got a commit but no result was expected", name);
      end else begin
         e = sb_q.pop_front();
         check({name, " is_collide"}, 32'(is_collide), 32'(e.col));
         check({name, " hazard"}, 32'(hazard), 32'(e.haz));
      end
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 25 && !seen; i++) begin
         @(negedge clk);
         if (scan_done) seen = 1'b1;
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("FAIL %s timeout: got no scan_done expected one within 25 cycles", name);
      end
   endtask

   task automatic commit_check(input string name);
      wait_done(name);
      compare_head(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected one before 100000 time units");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{0, 10'd300, 10'd300, 4'b0000, 1'b0};
      vecs[1]  = '{1, 10'd200, 10'd544, 4'b0100, 1'b0};
      vecs[2]  = '{0, 10'd0,   10'd300, 4'b0010, 1'b0};
      vecs[3]  = '{2, 10'd200, 10'd544, 4'b0000, 1'b1};
      vecs[4]  = '{3, 10'd210, 10'd544, 4'b0100, 1'b0};
      vecs[5]  = '{0, 10'd100, 10'd0,   4'b1000, 1'b0};
      vecs[6]  = '{0, 10'd776, 10'd100, 4'b0001, 1'b0};
      vecs[7]  = '{0, 10'd400, 10'd576, 4'b0100, 1'b0};
      vecs[8]  = '{0, 10'd0,   10'd0,   4'b1010, 1'b0};
      vecs[9]  = '{4, 10'd200, 10'd544, 4'b1000, 1'b0};
      vecs[10] = '{5, 10'd0,   10'd544, 4'b0010, 1'b1};
      vecs[11] = '{6, 10'd200, 10'd544, 4'b0001, 1'b0};
      vecs[12] = '{0, 10'd990, 10'd300, 4'b1111, 1'b0};

      rst_n = 1'b0;
      pos_x = 10'd300;
      pos_y = 10'd300;
      set_map(0);
      repeat (2) @(negedge clk);
      check("reset is_collide", 32'(is_collide), 32'd0);
      check("reset hazard", 32'(hazard), 32'd0);
      check("reset scan_done", 32'(scan_done), 32'd0);
      check("reset map_rd", 32'(map_rd), 32'd0);
      check("reset map_addr", 32'(map_addr), 32'd0);

      // Release: probes on cycles 1-8, first commit on the 10th edge.
      push_exp(4'b0000, 1'b0);
      rst_n = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         check($sformatf("boot cycle %0d map_rd", c), 32'(map_rd), (c <= 8) ? 32'd1 : 32'd0);
         check($sformatf("boot cycle %0d scan_done", c), 32'(scan_done), 32'd0);
      end
      @(negedge clk);
      check("boot edge 10 scan_done", 32'(scan_done), 32'd1);
      compare_head("boot scan");

      for (int v = 0; v < 13; v++) begin
         set_map(vecs[v].kind);
         pos_x = vecs[v].x;
         pos_y = vecs[v].y;
         push_exp(vecs[v].col, vecs[v].haz);
         commit_check($sformatf("vec %0d (%0d,%0d)", v, vecs[v].x, vecs[v].y));
      end

      // Left border: probes 4/5 suppressed and the address held at probe 3's tile.
      set_map(0);
      pos_x = 10'd0;
      pos_y = 10'd300;
      push_exp(4'b0010, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         check($sformatf("left cycle %0d map_rd", c), 32'(map_rd),
               (c <= 8 && c != 5 && c != 6) ? 32'd1 : 32'd0);
         if (c == 5 || c == 6)
            check($sformatf("left cycle %0d map_addr", c), 32'(map_addr), 32'd250);
      end
      @(negedge clk);
      check("left scan_done", 32'(scan_done), 32'd1);
      compare_head("left border");

      // Straddle: probe 2 and probe 3 land on adjacent tiles.
      set_map(3);
      pos_x = 10'd210;
      pos_y = 10'd544;
      push_exp(4'b0100, 1'b0);
      repeat (3) @(negedge clk);
      check("straddle probe2 addr", 32'(map_addr), 32'd456);
      @(negedge clk);
      check("straddle probe3 addr", 32'(map_addr), 32'd457);
      commit_check("straddle");

      // Snapshot: a position change mid-scan only affects the following scan.
      set_map(1);
      pos_x = 10'd200;
      pos_y = 10'd544;
      push_exp(4'b0100, 1'b0);
      repeat (3) @(negedge clk);
      check("snapshot held output", 32'(is_collide), 32'b0100);
      pos_y = 10'd300;
      push_exp(4'b0000, 1'b0);
      commit_check("snapshot current");
      commit_check("snapshot next");

      // Mid-scan reset: clear asynchronously during ISSUE k=4, never commit partials.
      set_map(5);
      pos_x = 10'd0;
      pos_y = 10'd544;
      push_exp(4'b0010, 1'b1);
      commit_check("pre-abort");
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort is_collide", 32'(is_collide), 32'd0);
      check("abort hazard", 32'(hazard), 32'd0);
      check("abort map_rd", 32'(map_rd), 32'd0);
      check("abort map_addr", 32'(map_addr), 32'd0);
      check("abort scan_done", 32'(scan_done), 32'd0);
      repeat (2) @(negedge clk);
      set_map(1);
      pos_x = 10'd200;
      pos_y = 10'd544;
      push_exp(4'b0100, 1'b0);
      rst_n = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         check($sformatf("post-abort cycle %0d scan_done", c), 32'(scan_done), 32'd0);
         check($sformatf("post-abort cycle %0d is_collide", c), 32'(is_collide), 32'd0);
      end
      @(negedge clk);
      check("post-abort edge 10 scan_done", 32'(scan_done), 32'd1);
      compare_head("post-abort scan");

      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
